alu_multicycle: RTL
===================

Name: alu_multicycle

Overview:
Registered, parametrised successor to the single-cycle accumulator ALU.
- Executes the existing R-type and I-type operation set behind a Start/Busy/Done handshake.
- Adds multi-cycle iterative operations: variable shifts and shift-add multiply.
- Sits between the decode stage and the accumulator/register-file writeback in the processor datapath.

Parameters:
WIDTH, 8, datapath width of AccumulatorIn, OperandIn and Out.
IMM_WIDTH, 5, width of ImmediateIn; zero-extended to WIDTH.
CNT_WIDTH, $clog2(WIDTH+1), iteration-counter width (derived, not overridden).

Ports:
Clk  input  1  clock; all state updates on rising edge
ResetN  input  1  synchronous active-low reset
Start  input  1  request; accepted only when Busy=0
Type  input  1  1 = R-type, 0 = I-type
RTypeOP  input  4  R-type opcode
ITypeOP  input  3  I-type opcode
AccumulatorIn  input  WIDTH  accumulator operand
OperandIn  input  WIDTH  register operand
ImmediateIn  input  IMM_WIDTH  immediate
Out  output  WIDTH  registered result; holds until next completion
ConditionalBranch  output  1  registered branch decision, valid with Done
Busy  output  1  multi-cycle operation in progress
Done  output  1  one-cycle pulse: Out/flags updated this cycle
IllegalOp  output  1  pulses with Done for an undefined opcode

Behaviour:
- Reset (ResetN=0 at edge): state=IDLE; Out=0; ConditionalBranch=0, Busy=0, Done=0, IllegalOp=0; counter=0. Reset mid-operation aborts it; no Done is produced.
- States:
  - IDLE: on Start, latch all inputs.
    - Single-cycle op: result registered at that edge; Done=1 next cycle (latency 1); stay IDLE.
    - Multi-cycle op: load counter=k; go to EXEC.
  - EXEC: Busy=1. Each edge performs one step and decrements the counter. At the edge where counter==1: write Out, Done=1, go to IDLE.
- Latency (Start edge to Done): single-cycle=1; shift=k+1; MUL=WIDTH+1. A shift with k=0 is treated as single-cycle.
- Start while Busy=1: ignored, with no side effects. Start in the Done cycle: accepted, because Busy is already 0.
- Done and IllegalOp are single-cycle pulses. ConditionalBranch is held until the next completion.
- Arithmetic: all arithmetic is unsigned, modulo 2^WIDTH.
- R-type opcodes:
  - 0 ADD: Acc+Opnd.
  - 1 LOAD, 3 MVTO, 8 STR: Out=Opnd.
  - 4 OR, 5 XOR, 7 AND: bitwise Acc op Opnd.
  - 6 XORR: Out=^Opnd, zero-extended.
  - 9 SLT: Out=(Acc<Opnd).
  - 10 SEQ: Out=(Acc==Opnd).
  - 11 BTRU: ConditionalBranch=(Acc==1); Out unchanged.
  - 12 SUB: Acc-Opnd.
  - 13 MUL: low WIDTH bits of Acc*Opnd, computed shift-add, one bit per cycle.
  - 14 LSLV / 15 LSRV: Acc shifted by k=min(Opnd,WIDTH), one bit per cycle.
- I-type opcodes:
  - 1 ADDI: Acc+Imm.
  - 2 SUBI: Acc-Imm.
  - 3 B: ConditionalBranch=1; Out unchanged.
  - 4 LSLI / 5 LSRI: shift by k=min(Imm,WIDTH), iterative.
- Undefined opcodes (R 2; I 0, 6, 7): latency 1; Out unchanged; ConditionalBranch=0; IllegalOp=1.
- ConditionalBranch is 0 for every completion other than B/BTRU.

Optional Feature:
ALU_MUL_EN
- Defined: R-type 13 performs the iterative MUL described above.
- Undefined: the multiplier datapath is absent, and opcode 13 is treated as undefined (latency 1, IllegalOp=1, Out unchanged).

Decomposition:
- Package alu_pkg:
  - r_op_t enum (4-bit) and i_op_t enum (3-bit) with the codes above.
  - state_t {IDLE, EXEC}.
  - is_multicycle() function returning 1 for MUL/LSLV/LSRV/LSLI/LSRI.
- One sub-module, alu_single_cycle: purely combinational evaluation of all single-cycle ops, returning result, branch and illegal flag.
- The top level holds the FSM, counter, shift/multiply registers and output registers.

Test Plan:
- Reset: ResetN=0 for 2 cycles, then 1 -> Out=0, Busy=0, Done=0, ConditionalBranch=0.
- ADD Acc=255, Opnd=55 -> Done 1 cycle after Start, Out=54, Busy never high. Then SUB 70-70 -> Out=0.
- LSLI Acc=16, Imm=3 -> Busy high 3 cycles, Done 4 cycles after Start, Out=128. LSRI Acc=16, Imm=3 -> Out=2. LSLI Imm=20 -> k=8, Out=0, Done 9 cycles after Start.
- MUL (ALU_MUL_EN defined), WIDTH=8:
  - 13*11 -> Done 9 cycles after Start, Out=143.
  - 20*20 -> Out=144.
  - Start pulses during Busy ignored; Out unchanged until Done.
  - New Start in the Done cycle accepted.
- Reset asserted at cycle 4 of a MUL -> no Done pulse, Out=0; the next ADD 1+1 -> Out=2.
- BTRU Acc=1 -> ConditionalBranch=1. BTRU Acc=2 -> 0. I-type op 7 -> IllegalOp=1, Out unchanged. MUL with ALU_MUL_EN undefined -> IllegalOp=1, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and decode helpers for the multi-cycle accumulator ALU.
// ALU_MUL_EN enables the iterative shift-add multiplier (R-type opcode 13).
package alu_pkg;

   typedef enum logic [3:0] {
      RAdd  = 4'd0,
      RLoad = 4'd1,
      RMvto = 4'd3,
      ROr   = 4'd4,
      RXor  = 4'd5,
      RXorr = 4'd6,
      RAnd  = 4'd7,
      RStr  = 4'd8,
      RSlt  = 4'd9,
      RSeq  = 4'd10,
      RBtru = 4'd11,
      RSub  = 4'd12,
      RMul  = 4'd13,
      RLslv = 4'd14,
      RLsrv = 4'd15
   } r_op_t;

   typedef enum logic [2:0] {
      IAddi = 3'd1,
      ISubi = 3'd2,
      IB    = 3'd3,
      ILsli = 3'd4,
      ILsri = 3'd5
   } i_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      McShl,
      McShr,
      McMul
   } mc_kind_t;

   function automatic logic is_multicycle(input logic       r_type,
                                          input logic [3:0] r_op,
                                          input logic [2:0] i_op);
      if (r_type) begin
`ifdef ALU_MUL_EN
         if (r_op == RMul) return 1'b1;
`endif
         return (r_op == RLslv) || (r_op == RLsrv);
      end
      return (i_op == ILsli) || (i_op == ILsri);
   endfunction

endpackage

// File: rtl/alu_single_cycle.sv
// Combinational evaluation of every single-cycle ALU operation.
// ALU_MUL_EN: when undefined, opcode 13 decodes as illegal here.
module alu_single_cycle
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             r_type,
   input  logic [3:0]       r_op,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] opnd,
   input  logic [WIDTH-1:0] imm,
   output logic [WIDTH-1:0] result,
   output logic             branch,
   output logic             illegal,
   output logic             wr_out
);

   always_comb begin
      result  = acc;
      branch  = 1'b0;
      illegal = 1'b0;
      wr_out  = 1'b1;
      if (r_type) begin
         case (r_op)
            RAdd:               result = acc + opnd;
            RLoad, RMvto, RStr: result = opnd;
            ROr:                result = acc | opnd;
            RXor:               result = acc ^ opnd;
            RAnd:               result = acc & opnd;
            RXorr:              result = WIDTH'(^opnd);
            RSlt:               result = WIDTH'(acc < opnd);
            RSeq:               result = WIDTH'(acc == opnd);
            RSub:               result = acc - opnd;
            RBtru: begin
               branch = (acc == WIDTH'(1));
               wr_out = 1'b0;
            end
            RMul: begin
`ifdef ALU_MUL_EN
               wr_out  = 1'b0;
`else
               illegal = 1'b1;
               wr_out  = 1'b0;
`endif
            end
            // Only reached with a zero shift amount: result is the unshifted accumulator.
            RLslv, RLsrv:       result = acc;
            default: begin
               illegal = 1'b1;
               wr_out  = 1'b0;
            end
         endcase
      end else begin
         case (i_op)
            IAddi:        result = acc + imm;
            ISubi:        result = acc - imm;
            IB: begin
               branch = 1'b1;
               wr_out = 1'b0;
            end
            ILsli, ILsri: result = acc;
            default: begin
               illegal = 1'b1;
               wr_out  = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Registered accumulator ALU with Start/Busy/Done handshake and iterative shifts/multiply.
// ALU_MUL_EN: include the shift-add multiplier datapath for R-type opcode 13.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned IMM_WIDTH = 5
) (
   input  logic                 Clk,
   input  logic                 ResetN,
   input  logic                 Start,
   input  logic                 Type,
   input  logic [3:0]           RTypeOP,
   input  logic [2:0]           ITypeOP,
   input  logic [WIDTH-1:0]     AccumulatorIn,
   input  logic [WIDTH-1:0]     OperandIn,
   input  logic [IMM_WIDTH-1:0] ImmediateIn,
   output logic [WIDTH-1:0]     Out,
   output logic                 ConditionalBranch,
   output logic                 Busy,
   output logic                 Done,
   output logic                 IllegalOp
);

   localparam int unsigned CNT_WIDTH = $clog2(WIDTH + 1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   mc_kind_t             kind_q, kind_d;
   logic [WIDTH-1:0]     sh_q, sh_d, sh_step;
   logic [WIDTH-1:0]     out_q, out_d;
   logic                 br_q, br_d;
   logic                 done_q, done_d;
   logic                 ill_q, ill_d;
`ifdef ALU_MUL_EN
   logic [WIDTH-1:0]     mpl_q, mpl_d;
   logic [WIDTH-1:0]     prod_q, prod_d, prod_step;
`endif

   logic [WIDTH-1:0]     imm_ext, amt;
   logic [CNT_WIDTH-1:0] k;
   mc_kind_t             mc_kind;
   logic                 mc_start;
   logic [WIDTH-1:0]     sc_result;
   logic                 sc_branch, sc_illegal, sc_wr;

   assign imm_ext = WIDTH'(ImmediateIn);

   alu_single_cycle #(
      .WIDTH (WIDTH)
   ) u_single (
      .r_type  (Type),
      .r_op    (RTypeOP),
      .i_op    (ITypeOP),
      .acc     (AccumulatorIn),
      .opnd    (OperandIn),
      .imm     (imm_ext),
      .result  (sc_result),
      .branch  (sc_branch),
      .illegal (sc_illegal),
      .wr_out  (sc_wr)
   );

   // Iteration count: clamped shift amount, or WIDTH for multiply.
   always_comb begin
      mc_kind = McShl;
      if (Type) begin
         if (RTypeOP == RLsrv) mc_kind = McShr;
`ifdef ALU_MUL_EN
         if (RTypeOP == RMul) mc_kind = McMul;
`endif
      end else if (ITypeOP == ILsri) begin
         mc_kind = McShr;
      end
      amt = Type ? OperandIn : imm_ext;
      if (mc_kind == McMul || amt > WIDTH'(WIDTH)) k = CNT_WIDTH'(WIDTH);
      else                                         k = amt[CNT_WIDTH-1:0];
      mc_start = is_multicycle(Type, RTypeOP, ITypeOP) && (k != '0);
   end

   assign sh_step = (kind_q == McShr) ? (sh_q >> 1) : (sh_q << 1);
`ifdef ALU_MUL_EN
   // sh_q doubles as the left-shifting multiplicand.
   assign prod_step = prod_q + (mpl_q[0] ? sh_q : '0);
`endif

   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         kind_q  <= McShl;
         sh_q    <= '0;
         out_q   <= '0;
         br_q    <= 1'b0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
`ifdef ALU_MUL_EN
         mpl_q   <= '0;
         prod_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kind_q  <= kind_d;
         sh_q    <= sh_d;
         out_q   <= out_d;
         br_q    <= br_d;
         done_q  <= done_d;
         ill_q   <= ill_d;
`ifdef ALU_MUL_EN
         mpl_q   <= mpl_d;
         prod_q  <= prod_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kind_d  = kind_q;
      sh_d    = sh_q;
      out_d   = out_q;
      br_d    = br_q;
      done_d  = 1'b0;
      ill_d   = 1'b0;
`ifdef ALU_MUL_EN
      mpl_d   = mpl_q;
      prod_d  = prod_q;
`endif
      case (state_q)
         IDLE: begin
            if (Start) begin
               if (mc_start) begin
                  state_d = EXEC;
                  cnt_d   = k;
                  kind_d  = mc_kind;
                  sh_d    = AccumulatorIn;
`ifdef ALU_MUL_EN
                  mpl_d   = OperandIn;
                  prod_d  = '0;
`endif
               end else begin
                  done_d = 1'b1;
                  ill_d  = sc_illegal;
                  br_d   = sc_branch;
                  if (sc_wr) out_d = sc_result;
               end
            end
         end
         EXEC: begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
            sh_d  = sh_step;
`ifdef ALU_MUL_EN
            mpl_d  = mpl_q >> 1;
            prod_d = prod_step;
`endif
            if (cnt_q == CNT_WIDTH'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               br_d    = 1'b0;
               out_d   = sh_step;
`ifdef ALU_MUL_EN
               if (kind_q == McMul) out_d = prod_step;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Out               = out_q;
      ConditionalBranch = br_q;
      Busy              = (state_q == EXEC);
      Done              = done_q;
      IllegalOp         = ill_q;
   end

endmodule
